// File: rtl/complex_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : complex_scale_ctrl
// Purpose  : Block-floating-point scale controller for the SDF IFFT datapath.
//            Observes one frame of NFFT complex samples and tracks the peak
//            part magnitude. At frame end it issues the arithmetic right-shift
//            amount for the next frame. It also keeps a saturating running
//            total of the issued shifts.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/in_ready, in_r/in_i - sample handshake and data
//            exp_clr         - clears exp_acc
//            shift_mag       - registered shift for the next frame
//            shift_valid     - one-cycle pulse when shift_mag updates
//            exp_acc         - saturating sum of issued shifts
// Revision : 1.0 - initial release
// ============================================================================
module complex_scale_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int NFFT       = 128,
    parameter int GUARD_BITS = 1,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_r,
    input  logic [DATA_WIDTH-1:0]   in_i,
    input  logic                    exp_clr,
    output logic [$clog2(NFFT):0]   shift_mag,
    output logic                    shift_valid,
    output logic [EXP_WIDTH-1:0]    exp_acc
);

    localparam int SW   = $clog2(NFFT) + 1;
    localparam int CW   = $clog2(NFFT);
    localparam int MW   = DATA_WIDTH - 1;
    localparam int SUMW = ((EXP_WIDTH > SW) ? EXP_WIDTH : SW) + 1;

    localparam logic [CW-1:0]        c_last    = CW'(NFFT - 1);
    localparam logic [SW-1:0]        c_guard   = SW'(GUARD_BITS);
    localparam logic [EXP_WIDTH-1:0] c_exp_max = {EXP_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_CALC  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [MW-1:0]          r_peak;

    logic [MW-1:0]          w_mag_r;
    logic [MW-1:0]          w_mag_i;
    logic [MW-1:0]          w_smp;
    logic [SW-1:0]          w_h;
    logic [SW-1:0]          w_shift;
    logic [EXP_WIDTH-1:0]   w_acc_base;
    logic [SUMW-1:0]        w_sum;
    logic [EXP_WIDTH-1:0]   w_acc_next;

    // One's-complement magnitude: the most negative value folds onto the
    // largest positive one, so the result always fits in MW bits.
    assign w_mag_r = in_r[DATA_WIDTH-1] ? ~in_r[MW-1:0] : in_r[MW-1:0];
    assign w_mag_i = in_i[DATA_WIDTH-1] ? ~in_i[MW-1:0] : in_i[MW-1:0];
    assign w_smp   = (w_mag_r > w_mag_i) ? w_mag_r : w_mag_i;

    // Leading-zero count of the peak; ascending scan so the highest set bit
    // is the last one to write w_h. A zero peak keeps the default MW.
    always_comb begin
        w_h = SW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (r_peak[i]) begin
                w_h = SW'(MW - 1 - i);
            end
        end
    end

    assign w_shift = (c_guard > w_h) ? (c_guard - w_h) : '0;

    // exp_clr on the update edge clears first, then the new shift is added.
    assign w_acc_base = exp_clr ? '0 : exp_acc;
    assign w_sum      = SUMW'(w_acc_base) + SUMW'(w_shift);
    assign w_acc_next = (w_sum > SUMW'(c_exp_max)) ? c_exp_max
                                                  : w_sum[EXP_WIDTH-1:0];

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == c_last)) begin
                    w_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_next = ST_ACCUM;
            end
            default: begin
                w_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_cnt       <= '0;
            r_peak      <= '0;
            shift_mag   <= '0;
            shift_valid <= 1'b0;
            exp_acc     <= '0;
        end else begin
            r_state     <= w_next;
            shift_valid <= (r_state == ST_CALC);
            if (r_state == ST_CALC) begin
                shift_mag <= w_shift;
                exp_acc   <= w_acc_next;
                r_peak    <= '0;
                r_cnt     <= '0;
            end else begin
                if (exp_clr) begin
                    exp_acc <= '0;
                end
                if (in_valid) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_smp > r_peak) begin
                        r_peak <= w_smp;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_scale_ctrl
// Purpose  : Self-checking bench for complex_scale_ctrl. Two instances share
//            the stimulus: dut_a (GUARD_BITS 1, EXP_WIDTH 8) and dut_b
//            (GUARD_BITS 3, EXP_WIDTH 2, saturates at 3). Expected shifts and
//            totals are hand-computed per frame and queued; a monitor pops
//            them on each shift_valid. A small handshake model predicts the
//            CALC bubble and the shift_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_scale_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               exp_clr;
    logic signed [15:0] in_r;
    logic signed [15:0] in_i;

    logic               a_ready, b_ready, a_sv, b_sv;
    logic [7:0]         a_shift, b_shift;
    logic [7:0]         a_acc;
    logic [1:0]         b_acc;

    always #5 clk = ~clk;

    complex_scale_ctrl #(.DATA_WIDTH(16), .NFFT(128), .GUARD_BITS(1), .EXP_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
        .in_r(in_r), .in_i(in_i), .exp_clr(exp_clr), .shift_mag(a_shift),
        .shift_valid(a_sv), .exp_acc(a_acc)
    );

    complex_scale_ctrl #(.DATA_WIDTH(16), .NFFT(128), .GUARD_BITS(3), .EXP_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready),
        .in_r(in_r), .in_i(in_i), .exp_clr(exp_clr), .shift_mag(b_shift),
        .shift_valid(b_sv), .exp_acc(b_acc)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q_a_shift[$];
    logic [7:0] q_a_acc[$];
    logic [7:0] q_b_shift[$];
    logic [1:0] q_b_acc[$];

    int  m_xfer;
    bit  m_calc;
    bit  m_sv;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Handshake model: 128 transfers then one CALC cycle, shift_valid after.
    always @(posedge clk) begin
        if (rst) begin
            m_xfer <= 0;
            m_calc <= 1'b0;
            m_sv   <= 1'b0;
        end else begin
            m_sv <= m_calc;
            if (m_calc) begin
                m_calc <= 1'b0;
            end else if (in_valid) begin
                if (m_xfer == 127) begin
                    m_xfer <= 0;
                    m_calc <= 1'b1;
                end else begin
                    m_xfer <= m_xfer + 1;
                end
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_in_ready", {31'd0, a_ready}, {31'd0, !m_calc});
            chk("b_in_ready", {31'd0, b_ready}, {31'd0, !m_calc});
            chk("a_shift_valid", {31'd0, a_sv}, {31'd0, m_sv});
            chk("b_shift_valid", {31'd0, b_sv}, {31'd0, m_sv});
            if (a_sv === 1'b1) begin
                if (q_a_shift.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_pulse actual=1 expected=0");
                end else begin
                    chk("a_shift_mag", {24'd0, a_shift}, {24'd0, q_a_shift.pop_front()});
                    chk("a_exp_acc", {24'd0, a_acc}, {24'd0, q_a_acc.pop_front()});
                end
            end
            if (b_sv === 1'b1) begin
                if (q_b_shift.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_pulse actual=1 expected=0");
                end else begin
                    chk("b_shift_mag", {24'd0, b_shift}, {24'd0, q_b_shift.pop_front()});
                    chk("b_exp_acc", {30'd0, b_acc}, {30'd0, q_b_acc.pop_front()});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample transferred.
    task automatic send_sample(input logic signed [15:0] r, input logic signed [15:0] i,
                               input bit allow_gap);
        int n;
        if (allow_gap && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        in_r     = r;
        in_i     = i;
        in_valid = 1'b1;
        n = 0;
        while (!a_ready && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int pos, input logic signed [15:0] r, input logic signed [15:0] i,
                         input logic signed [15:0] fill, input bit clr_end,
                         input logic [7:0] as, input logic [7:0] aa,
                         input logic [7:0] bs, input logic [1:0] ba);
        q_a_shift.push_back(as);
        q_a_acc.push_back(aa);
        q_b_shift.push_back(bs);
        q_b_acc.push_back(ba);
        for (int n = 0; n < 128; n++) begin
            if (n == pos) send_sample(r, i, n != 0);
            else          send_sample(fill, fill, n != 0);
        end
        if (clr_end) begin
            // Now in the CALC cycle: clear lands on the update edge.
            in_valid = 1'b0;
            exp_clr  = 1'b1;
            @(posedge clk);
            #1;
            exp_clr  = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_clr  = 1'b0;
        in_r     = '0;
        in_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        chk("reset_a_shift", {24'd0, a_shift}, 32'd0);
        chk("reset_a_acc", {24'd0, a_acc}, 32'd0);
        chk("reset_b_acc", {30'd0, b_acc}, 32'd0);
        chk("reset_ready", {31'd0, a_ready}, 32'd1);

        //            pos  r       i       fill clr  a_s a_acc b_s b_acc
        frame(-1,     16'sd0,      16'sd0,      16'sd0,  0, 8'd0, 8'd0, 8'd0, 2'd0);
        frame(5,      16'sd16384,  16'sd0,      16'sd0,  0, 8'd1, 8'd1, 8'd3, 2'd3);
        frame(127,    16'sd0,     -16'sd32768,  16'sd0,  0, 8'd1, 8'd2, 8'd3, 2'd3);
        // Sample 0 of this frame is held through the previous CALC cycle.
        frame(0,     -16'sd4096,   16'sd4096,   16'sd0,  0, 8'd0, 8'd2, 8'd1, 2'd3);

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_clr = 1'b1;
        @(posedge clk);
        #1;
        exp_clr = 1'b0;
        chk("clr_a_acc", {24'd0, a_acc}, 32'd0);
        chk("clr_b_acc", {30'd0, b_acc}, 32'd0);
        chk("hold_a_shift", {24'd0, a_shift}, 32'd0);
        chk("hold_b_shift", {24'd0, b_shift}, 32'd1);

        frame(70,     16'sd8192,   16'sd0,      16'sd0,  0, 8'd0, 8'd0, 8'd2, 2'd2);
        frame(30,     16'sd2048,  -16'sd2049,   16'sd0,  0, 8'd0, 8'd0, 8'd0, 2'd2);
        frame(-1,     16'sd0,      16'sd0,     -16'sd1,  0, 8'd0, 8'd0, 8'd0, 2'd2);
        frame(99,     16'sd16384,  16'sd0,      16'sd0,  1, 8'd1, 8'd1, 8'd3, 2'd3);
        frame(3,      16'sd0,      16'sd16384,  16'sd0,  0, 8'd1, 8'd2, 8'd3, 2'd3);

        // Partial frame of large samples, then reset discards it.
        for (int n = 0; n < 60; n++) send_sample(16'sd16384, 16'sd16384, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_a_shift", {24'd0, a_shift}, 32'd0);
        chk("midrst_a_acc", {24'd0, a_acc}, 32'd0);
        chk("midrst_b_shift", {24'd0, b_shift}, 32'd0);
        chk("midrst_b_acc", {30'd0, b_acc}, 32'd0);
        chk("midrst_sv", {31'd0, a_sv}, 32'd0);

        frame(-1,     16'sd0,      16'sd0,      16'sd0,  0, 8'd0, 8'd0, 8'd0, 2'd0);

        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("a_queue_drained", q_a_shift.size(), 32'd0);
        chk("b_queue_drained", q_b_shift.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
